// File: rtl/rs_dispatch_bank.sv
// Bank of add/sub reservation stations with CDB wakeup and an oldest-first
// dispatcher feeding one arithmetic unit through a valid/ready register.
module rs_dispatch_bank #(
    parameter int unsigned NUM_RS = 4,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned TAG_W  = 3,
    parameter int unsigned OP_W   = 3,
    parameter int unsigned AGE_W  = 10
) (
    input  logic              CLK,
    input  logic              CLR,
    input  logic              flush,
    input  logic              issue_valid,
    output logic              issue_ready,
    input  logic [OP_W-1:0]   issue_op,
    input  logic [TAG_W-1:0]  issue_tag_a,
    input  logic [DATA_W-1:0] issue_val_a,
    input  logic [TAG_W-1:0]  issue_tag_b,
    input  logic [DATA_W-1:0] issue_val_b,
    output logic [TAG_W-1:0]  alloc_tag,
    input  logic              cdb_valid,
    input  logic [TAG_W-1:0]  cdb_tag,
    input  logic [DATA_W-1:0] cdb_data,
    output logic              disp_valid,
    input  logic              disp_ready,
    output logic [OP_W-1:0]   disp_op,
    output logic [DATA_W-1:0] disp_a,
    output logic [DATA_W-1:0] disp_b,
    output logic [TAG_W-1:0]  disp_tag,
    output logic [NUM_RS-1:0] busy
);

    localparam int unsigned IDX_W = (NUM_RS > 1) ? $clog2(NUM_RS) : 1;

    logic [OP_W-1:0]   ent_op    [NUM_RS];
    logic [TAG_W-1:0]  ent_tag_a [NUM_RS];
    logic [DATA_W-1:0] ent_val_a [NUM_RS];
    logic [TAG_W-1:0]  ent_tag_b [NUM_RS];
    logic [DATA_W-1:0] ent_val_b [NUM_RS];
    logic [AGE_W-1:0]  ent_age   [NUM_RS];
    logic [AGE_W-1:0]  age_ctr;

    logic [NUM_RS-1:0] ent_ready;
    logic              free_found;
    logic [IDX_W-1:0]  free_idx;
    logic              sel_found;
    logic [IDX_W-1:0]  sel_idx;
    logic [AGE_W-1:0]  age_diff;
    logic              accept;
    logic              load;
    logic              cdb_live;
    logic              byp_a;
    logic              byp_b;

    // Lowest-index free entry for allocation.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int unsigned i = 0; i < NUM_RS; i++) begin
            if (!busy[i] && !free_found) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end
    end

    assign issue_ready = !flush && free_found;
    assign accept      = issue_valid && issue_ready;
    assign alloc_tag   = accept ? (TAG_W'(free_idx) + TAG_W'(1)) : '0;
    assign cdb_live    = cdb_valid && (cdb_tag != '0);
    assign byp_a       = cdb_live && (cdb_tag == issue_tag_a);
    assign byp_b       = cdb_live && (cdb_tag == issue_tag_b);

    // Oldest ready entry; the modular age difference keeps ordering valid across wrap.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        age_diff  = '0;
        ent_ready = '0;
        for (int unsigned i = 0; i < NUM_RS; i++) begin
            ent_ready[i] = busy[i] && (ent_tag_a[i] == '0) && (ent_tag_b[i] == '0);
            if (ent_ready[i]) begin
                if (!sel_found) begin
                    sel_found = 1'b1;
                    sel_idx   = IDX_W'(i);
                end else begin
                    age_diff = ent_age[i] - ent_age[sel_idx];
                    if (age_diff[AGE_W-1]) begin
                        sel_idx = IDX_W'(i);
                    end
                end
            end
        end
    end

    assign load = (!disp_valid || disp_ready) && sel_found;

    always_ff @(posedge CLK) begin
        if (!CLR) begin
            busy       <= '0;
            disp_valid <= 1'b0;
            disp_op    <= '0;
            disp_a     <= '0;
            disp_b     <= '0;
            disp_tag   <= '0;
            age_ctr    <= '0;
            for (int unsigned i = 0; i < NUM_RS; i++) begin
                ent_op[i]    <= '0;
                ent_tag_a[i] <= '0;
                ent_val_a[i] <= '0;
                ent_tag_b[i] <= '0;
                ent_val_b[i] <= '0;
                ent_age[i]   <= '0;
            end
        end else if (flush) begin
            busy       <= '0;
            disp_valid <= 1'b0;
            age_ctr    <= '0;
        end else begin
            // CDB wakeup of pending operands in occupied entries.
            for (int unsigned i = 0; i < NUM_RS; i++) begin
                if (busy[i] && cdb_live) begin
                    if (ent_tag_a[i] == cdb_tag) begin
                        ent_tag_a[i] <= '0;
                        ent_val_a[i] <= cdb_data;
                    end
                    if (ent_tag_b[i] == cdb_tag) begin
                        ent_tag_b[i] <= '0;
                        ent_val_b[i] <= cdb_data;
                    end
                end
            end

            if (accept) begin
                busy[free_idx]      <= 1'b1;
                ent_op[free_idx]    <= issue_op;
                ent_tag_a[free_idx] <= byp_a ? '0 : issue_tag_a;
                ent_val_a[free_idx] <= byp_a ? cdb_data : issue_val_a;
                ent_tag_b[free_idx] <= byp_b ? '0 : issue_tag_b;
                ent_val_b[free_idx] <= byp_b ? cdb_data : issue_val_b;
                ent_age[free_idx]   <= age_ctr;
                age_ctr             <= age_ctr + AGE_W'(1);
            end

            if (load) begin
                busy[sel_idx] <= 1'b0;
                disp_valid    <= 1'b1;
                disp_op       <= ent_op[sel_idx];
                disp_a        <= ent_val_a[sel_idx];
                disp_b        <= ent_val_b[sel_idx];
                disp_tag      <= TAG_W'(sel_idx) + TAG_W'(1);
            end else if (disp_ready) begin
                disp_valid <= 1'b0;
            end
        end
    end

endmodule
